// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_pkg
// Description : Shared types and constants for the simplified LC-3 datapath.
//               Holds the bus width, register-index and condition-code types,
//               and the one-hot NZP encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_pkg;

    localparam int DATA_W = 16;

    typedef logic [2:0] reg_idx_t;
    typedef logic [2:0] nzp_t;

    localparam nzp_t NZP_N = 3'b100;
    localparam nzp_t NZP_Z = 3'b010;
    localparam nzp_t NZP_P = 3'b001;

endpackage
`default_nettype wire

// File: rtl/reg_16.sv
`default_nettype none
// ============================================================================
// Module      : reg_16
// Description : Single DATA_W-wide register with load enable and asynchronous
//               active-high reset to zero.
// Ports       : Clk     - rising-edge clock
//               Reset   - asynchronous active-high clear
//               i_ld    - load enable, captures i_d at the edge
//               i_d     - data to load
//               o_q     - current register contents
// Revision    : 1.0 - initial release
// ============================================================================
module reg_16 #(
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_ld,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_q <= '0;
        end else if (i_ld) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Eight-entry general-purpose register file with NZP condition
//               codes for the simplified LC-3 datapath. Writes are steered by
//               the decoder's one-hot R0..R7 lines gated by LD_REG; two
//               combinational read ports feed the ALU and address adders.
// Ports       : Clk, Reset        - clock, async active-high reset
//               LD_REG            - register write strobe
//               R0..R7            - one-hot destination select
//               Data_in           - CPU bus value
//               LD_CC             - condition-code load strobe
//               SR1_SEL, SR2_SEL  - read-port register indices
//               SR1_OUT, SR2_OUT  - read-port data
//               NZP               - condition codes {N,Z,P}
//               ERR_SEL           - sticky illegal-select flag
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_W = lc3_pkg::DATA_W,
    parameter bit BYPASS = 1'b0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              LD_REG,
    input  logic              R0,
    input  logic              R1,
    input  logic              R2,
    input  logic              R3,
    input  logic              R4,
    input  logic              R5,
    input  logic              R6,
    input  logic              R7,
    input  logic [DATA_W-1:0] Data_in,
    input  logic              LD_CC,
    input  lc3_pkg::reg_idx_t SR1_SEL,
    input  lc3_pkg::reg_idx_t SR2_SEL,
    output logic [DATA_W-1:0] SR1_OUT,
    output logic [DATA_W-1:0] SR2_OUT,
    output lc3_pkg::nzp_t     NZP,
    output logic              ERR_SEL
);

    import lc3_pkg::*;

    localparam int c_NREGS = 8;

    logic [c_NREGS-1:0] w_sel;
    logic [3:0]         w_cnt;
    logic               w_onehot;
    logic               w_wr_ok;
    logic               w_wr_bad;
    logic [DATA_W-1:0]  w_q [c_NREGS];
    nzp_t               w_nzp_next;
    nzp_t               r_nzp;
    logic               r_err;

    assign w_sel = {R7, R6, R5, R4, R3, R2, R1, R0};

    // Legal write needs exactly one select bit set.
    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < c_NREGS; i++) begin
            w_cnt = w_cnt + {3'b000, w_sel[i]};
        end
        w_onehot = (w_cnt == 4'd1);
    end

    assign w_wr_ok  = LD_REG &  w_onehot;
    assign w_wr_bad = LD_REG & ~w_onehot;

    for (genvar gi = 0; gi < c_NREGS; gi++) begin : g_regs
        reg_16 #(
            .DATA_W (DATA_W)
        ) u_reg (
            .Clk   (Clk),
            .Reset (Reset),
            .i_ld  (w_wr_ok & w_sel[gi]),
            .i_d   (Data_in),
            .o_q   (w_q[gi])
        );
    end

    // Read ports. With forwarding enabled, a legal write to the selected
    // register shows its incoming value before the edge.
    always_comb begin
        SR1_OUT = w_q[SR1_SEL];
        if (BYPASS && w_wr_ok && w_sel[SR1_SEL]) begin
            SR1_OUT = Data_in;
        end
    end

    always_comb begin
        SR2_OUT = w_q[SR2_SEL];
        if (BYPASS && w_wr_ok && w_sel[SR2_SEL]) begin
            SR2_OUT = Data_in;
        end
    end

    // Sign bit takes priority, so exactly one NZP bit is ever produced.
    always_comb begin
        w_nzp_next = NZP_P;
        if (Data_in[DATA_W-1]) begin
            w_nzp_next = NZP_N;
        end else if (Data_in == '0) begin
            w_nzp_next = NZP_Z;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_nzp <= NZP_Z;
        end else if (LD_CC) begin
            r_nzp <= w_nzp_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_err <= 1'b0;
        end else if (w_wr_bad) begin
            r_err <= 1'b1;
        end
    end

    assign NZP     = r_nzp;
    assign ERR_SEL = r_err;

endmodule
`default_nettype wire

// File: doc/reg_file.md
# reg_file

Eight-entry, 16-bit general-purpose register file for the simplified LC-3 datapath. It sits directly downstream of the destination-register decoder and consumes its one-hot R0–R7 select lines, gated by LD_REG, to capture the value on the CPU bus. It provides two combinational source-read ports (SR1/SR2) to the ALU and address adders. It also holds the NZP condition-code register, which is updated from the same bus value.

## Interface

- DATA_W, 16, register and bus width
- BYPASS, 0, 1 = same-cycle write-to-read forwarding on both read ports
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; clears all state
- LD_REG  in  1  register write strobe
- R0, R1, R2, R3, R4, R5, R6, R7  in  1 each  one-hot destination select from decoder
- Data_in  in  DATA_W  CPU bus value to write
- LD_CC  in  1  condition-code load strobe
- SR1_SEL  in  3  read-port-1 register index
- SR2_SEL  in  3  read-port-2 register index
- SR1_OUT  out  DATA_W  contents of register SR1_SEL
- SR2_OUT  out  DATA_W  contents of register SR2_SEL
- NZP  out  3  condition codes {N,Z,P}
- ERR_SEL  out  1  sticky flag: write attempted with non-one-hot select

## Operation

- Write: on rising Clk with LD_REG=1 and {R7..R0} exactly one-hot, the selected register loads Data_in. All other registers hold.
- Illegal select: LD_REG=1 with {R7..R0} all-zero or more than one bit set. No register is written, and ERR_SEL sets to 1 at that edge. ERR_SEL stays set until Reset.
- LD_REG=0: the select lines are ignored entirely, and ERR_SEL is not affected by them.
- Read: SR1_OUT and SR2_OUT are combinational muxes on the register array. Both ports may select the same register.
- BYPASS=1: if LD_REG=1, the select is legal, and SRx_SEL matches the one-hot index, then SRx_OUT = Data_in in the same cycle.
- BYPASS=0: reads return the pre-edge value; the new value is visible after the edge.
- Condition codes: on rising Clk with LD_CC=1, NZP is set from Data_in:
  - N=1 (100) if bit DATA_W-1 is set;
  - Z=1 (010) if Data_in is zero;
  - P=1 (001) otherwise.
  - Exactly one bit of NZP is ever set.
- LD_CC is independent of LD_REG and the select lines. Both may occur in the same cycle, and both take effect.
- An illegal select does not suppress the LD_CC update.

## Timing

- Write latency: 1 cycle. Data_in is sampled at the edge and appears on SRx_OUT in the same delta after the edge.
- Read latency: 0 cycles (combinational from SRx_SEL and the register array).
- Reset asserted (async, any time, including mid-write):
  - all registers become 0x0000 immediately;
  - NZP becomes 3'b010;
  - ERR_SEL becomes 0;
  - SR1_OUT/SR2_OUT become 0x0000 (for BYPASS=1, only if LD_REG=0).
- Reset dominates: no write, CC update or ERR_SEL set occurs at an edge while Reset=1.
- Back-to-back writes to the same register on consecutive cycles: the last value wins each cycle, with no stall.
- No handshake and no backpressure; every legal strobe completes in one cycle.

## Structure

- Shared package lc3_pkg holds:
  - localparam DATA_W = 16;
  - typedef logic [2:0] reg_idx_t;
  - typedef logic [2:0] nzp_t;
  - constants NZP_N = 3'b100, NZP_Z = 3'b010, NZP_P = 3'b001.
- One natural sub-module, reg_16: a single DATA_W register with async Reset, Clk and load enable, instantiated eight times.
- Implement the one-hot legality check (popcount == 1) and the CC generation inline as always_comb logic.

## Test plan

- Reset, then LD_REG=1, R3=1, Data_in=0xBEEF, one edge; SR1_SEL=3 -> SR1_OUT=0xBEEF, and all other registers still read 0x0000.
- Write 0x8001 to R5 with LD_CC=1, then 0x0000 with LD_CC=1, then 0x0042 with LD_CC=1 -> NZP sequence 100, 010, 001.
- LD_REG=1 with R1=R2=1, Data_in=0x1234 -> R1 and R2 unchanged, ERR_SEL=1. Drop LD_REG -> ERR_SEL stays 1 until Reset.
- BYPASS=1: write 0x5A5A to R7 with SR1_SEL=SR2_SEL=7 -> both outputs read 0x5A5A before the edge. With BYPASS=0 they read the old value until after the edge.
- Assert Reset asynchronously mid-cycle after loading 0xFFFF into R0 -> SR1_OUT (SEL=0) reads 0x0000 immediately, NZP=010, and the next edge with LD_REG=1 does not write while Reset is held.
- LD_REG=1 with all R lines low and LD_CC=1, Data_in=0xF000 -> no register changes, ERR_SEL=1, NZP=100.
